// File: rtl/ifft_butterfly_pipe.sv
// ifft_butterfly_pipe: three-stage radix-2 inverse FFT butterfly.
//   t = v * conj(w), a = u + t, b = u - t, with optional halving and
//   saturation to NB_W bits. One global advance enable stalls all stages.
//
// Handshake (valid/ready):
//   A beat is accepted on a rising edge where i_valid && o_ready, and it is
//   consumed on a rising edge where o_valid && i_ready. o_ready = en, where
//   en = !o_valid || i_ready. Every stage shifts only when en is 1, so
//   o_valid and the o_a*/o_b* outputs hold steady while o_valid && !i_ready.
//   Invalid slots (bubbles) travel through the stages like data.
module ifft_butterfly_pipe #(
    parameter int NB_W  = 17,
    parameter int NBF_W = 10,
    parameter int SCALE = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic signed [NB_W-1:0] i_uI,
    input  logic signed [NB_W-1:0] i_uQ,
    input  logic signed [NB_W-1:0] i_vI,
    input  logic signed [NB_W-1:0] i_vQ,
    input  logic signed [NB_W-1:0] i_wI,
    input  logic signed [NB_W-1:0] i_wQ,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic signed [NB_W-1:0] o_aI,
    output logic signed [NB_W-1:0] o_aQ,
    output logic signed [NB_W-1:0] o_bI,
    output logic signed [NB_W-1:0] o_bQ,
    input  logic                   i_clr,
    output logic                   o_sat_flag,
    output logic [15:0]            o_sat_cnt
);

    localparam int PW = 2 * NB_W;       // full product width
    localparam int SW = 2 * NB_W + 1;   // product-sum width
    localparam int AW = NB_W + 1;       // add/sub width

    localparam logic signed [NB_W-1:0] NB_MAX = {1'b0, {(NB_W-1){1'b1}}};
    localparam logic signed [NB_W-1:0] NB_MIN = {1'b1, {(NB_W-1){1'b0}}};
    localparam logic signed [SW-1:0]   T_MAX  = {{(SW-NB_W+1){1'b0}}, {(NB_W-1){1'b1}}};
    localparam logic signed [SW-1:0]   T_MIN  = {{(SW-NB_W+1){1'b1}}, {(NB_W-1){1'b0}}};
    localparam logic signed [AW-1:0]   A_MAX  = {{(AW-NB_W+1){1'b0}}, {(NB_W-1){1'b1}}};
    localparam logic signed [AW-1:0]   A_MIN  = {{(AW-NB_W+1){1'b1}}, {(NB_W-1){1'b0}}};

    // Clamp a product-sum to NB_W bits.
    function automatic logic signed [NB_W-1:0] sat_t(input logic signed [SW-1:0] x);
        if (x > T_MAX)      return NB_MAX;
        else if (x < T_MIN) return NB_MIN;
        else                return x[NB_W-1:0];
    endfunction

    function automatic logic clip_t(input logic signed [SW-1:0] x);
        return (x > T_MAX) || (x < T_MIN);
    endfunction

    // Clamp an add/sub result to NB_W bits.
    function automatic logic signed [NB_W-1:0] sat_a(input logic signed [AW-1:0] x);
        if (x > A_MAX)      return NB_MAX;
        else if (x < A_MIN) return NB_MIN;
        else                return x[NB_W-1:0];
    endfunction

    function automatic logic clip_a(input logic signed [AW-1:0] x);
        return (x > A_MAX) || (x < A_MIN);
    endfunction

    logic en;
    assign en      = !o_valid || i_ready;
    assign o_ready = en;

    // ---------------- stage 1: products and u ----------------
    logic                   s1_valid;
    logic signed [PW-1:0]   s1_p_ii, s1_p_qq, s1_p_qi, s1_p_iq;
    logic signed [NB_W-1:0] s1_uI, s1_uQ;

    // Register the four full-precision products and the u operand.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1_valid <= 1'b0;
            s1_p_ii  <= '0;
            s1_p_qq  <= '0;
            s1_p_qi  <= '0;
            s1_p_iq  <= '0;
            s1_uI    <= '0;
            s1_uQ    <= '0;
        end else if (en) begin
            s1_valid <= i_valid;
            s1_p_ii  <= i_vI * i_wI;
            s1_p_qq  <= i_vQ * i_wQ;
            s1_p_qi  <= i_vQ * i_wI;
            s1_p_iq  <= i_vI * i_wQ;
            s1_uI    <= i_uI;
            s1_uQ    <= i_uQ;
        end
    end

    // ---------------- stage 2: t = v * conj(w), saturated ----------------
    logic signed [SW-1:0]   sum_ti, sum_tq, shf_ti, shf_tq;

    // Product sums in SW bits, then floor shift back to the operand scale.
    always_comb begin
        sum_ti = {s1_p_ii[PW-1], s1_p_ii} + {s1_p_qq[PW-1], s1_p_qq};
        sum_tq = {s1_p_qi[PW-1], s1_p_qi} - {s1_p_iq[PW-1], s1_p_iq};
        shf_ti = sum_ti >>> NBF_W;
        shf_tq = sum_tq >>> NBF_W;
    end

    logic                   s2_valid;
    logic                   s2_tsat;
    logic signed [NB_W-1:0] s2_tI, s2_tQ, s2_uI, s2_uQ;

    // Register saturated t, its clip status, and u.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s2_valid <= 1'b0;
            s2_tsat  <= 1'b0;
            s2_tI    <= '0;
            s2_tQ    <= '0;
            s2_uI    <= '0;
            s2_uQ    <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_tsat  <= clip_t(shf_ti) || clip_t(shf_tq);
            s2_tI    <= sat_t(shf_ti);
            s2_tQ    <= sat_t(shf_tq);
            s2_uI    <= s1_uI;
            s2_uQ    <= s1_uQ;
        end
    end

    // ---------------- stage 3: a = u + t, b = u - t ----------------
    logic signed [AW-1:0] add_i, add_q, sub_i, sub_q;
    logic signed [AW-1:0] scl_ai, scl_aq, scl_bi, scl_bq;
    logic                 s3_event;

    // Widened add/sub, optional halving, and the per-beat saturation event.
    always_comb begin
        add_i = {s2_uI[NB_W-1], s2_uI} + {s2_tI[NB_W-1], s2_tI};
        add_q = {s2_uQ[NB_W-1], s2_uQ} + {s2_tQ[NB_W-1], s2_tQ};
        sub_i = {s2_uI[NB_W-1], s2_uI} - {s2_tI[NB_W-1], s2_tI};
        sub_q = {s2_uQ[NB_W-1], s2_uQ} - {s2_tQ[NB_W-1], s2_tQ};
        if (SCALE != 0) begin
            scl_ai = add_i >>> 1;
            scl_aq = add_q >>> 1;
            scl_bi = sub_i >>> 1;
            scl_bq = sub_q >>> 1;
        end else begin
            scl_ai = add_i;
            scl_aq = add_q;
            scl_bi = sub_i;
            scl_bq = sub_q;
        end
        s3_event = s2_valid && (s2_tsat || clip_a(scl_ai) || clip_a(scl_aq) ||
                                clip_a(scl_bi) || clip_a(scl_bq));
    end

    // Output register: the final stage drives o_valid and the results.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_aI    <= '0;
            o_aQ    <= '0;
            o_bI    <= '0;
            o_bQ    <= '0;
        end else if (en) begin
            o_valid <= s2_valid;
            o_aI    <= sat_a(scl_ai);
            o_aQ    <= sat_a(scl_aq);
            o_bI    <= sat_a(scl_bi);
            o_bQ    <= sat_a(scl_bq);
        end
    end

    // Sticky saturation status; clear takes priority over a same-cycle event.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_sat_flag <= 1'b0;
            o_sat_cnt  <= '0;
        end else if (i_clr) begin
            o_sat_flag <= 1'b0;
            o_sat_cnt  <= '0;
        end else if (en && s3_event) begin
            o_sat_flag <= 1'b1;
            if (o_sat_cnt != 16'hFFFF) o_sat_cnt <= o_sat_cnt + 16'd1;
        end
    end

endmodule
